// File: rtl/lsu_pkg.sv
// Shared definitions for the buffered load/store unit.
//   - access size encodings (SZ_B / SZ_H / SZ_W)
//   - FSM state enum
//   - mc_len_of:   size encoding -> byte count for the memory controller
//   - load_extend: right-justified read data -> sign/zero-extended result
//   - store_mask:  rs2 value -> right-justified data with unused bytes cleared
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    ST_WAIT = 2'd2,
    LD_DONE = 2'd3
  } lsu_state_e;

  // The reserved size code 3 is treated as a word access.
  function automatic logic [2:0] mc_len_of(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned);
    case (size)
      SZ_B:    return is_unsigned ? {24'h0, rdata[7:0]}
                                  : {{24{rdata[7]}}, rdata[7:0]};
      SZ_H:    return is_unsigned ? {16'h0, rdata[15:0]}
                                  : {{16{rdata[15]}}, rdata[15:0]};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] store_mask(input logic [31:0] data,
                                             input logic [1:0]  size);
    case (size)
      SZ_B:    return {24'h0, data[7:0]};
      SZ_H:    return {16'h0, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_store_buffer.sv
// Circular store FIFO with a parallel word-address probe.
// Ports:
//   clk_in, rst_in          clock, async active-low reset
//   push, push_*            enqueue {addr, data, len} at tail (caller ensures !full)
//   pop                     drop the head entry (caller ensures count>0)
//   probe_word              word address (byte address >> 2) to compare
//   head_addr/data/len      oldest entry
//   count, full             occupancy
//   conflict                some valid entry shares probe_word
module lsu_store_buffer #(
  parameter int ADDR_W   = 32,
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      push,
  input  logic                      pop,
  input  logic [ADDR_W-1:0]         push_addr,
  input  logic [XLEN-1:0]           push_data,
  input  logic [2:0]                push_len,
  input  logic [ADDR_W-3:0]         probe_word,
  output logic [ADDR_W-1:0]         head_addr,
  output logic [XLEN-1:0]           head_data,
  output logic [2:0]                head_len,
  output logic [$clog2(SB_DEPTH):0] count,
  output logic                      full,
  output logic                      conflict
);

  localparam int PW = $clog2(SB_DEPTH);

  logic [ADDR_W-1:0] addr_q [SB_DEPTH];
  logic [XLEN-1:0]   data_q [SB_DEPTH];
  logic [2:0]        len_q  [SB_DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [PW:0]       count_q;
  logic [SB_DEPTH-1:0] valid_vec;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail_q] <= push_addr;
        data_q[tail_q] <= push_data;
        len_q[tail_q]  <= push_len;
        tail_q         <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    valid_vec = '0;
    conflict  = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      valid_vec[i] = ({1'b0, PW'(i) - head_q} < count_q);
      if (valid_vec[i] && (addr_q[i][ADDR_W-1:2] == probe_word)) conflict = 1'b1;
    end
  end

  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign head_len  = len_q[head_q];
  assign count     = count_q;
  assign full      = (count_q == (PW+1)'(SB_DEPTH));

endmodule

// File: rtl/mem_lsu_buffered.sv
// Memory-access stage between ex_mem and mem_wb. Stores are posted into a
// store buffer and drained in the background; loads run through a
// registered FSM and are extended to XLEN before writeback.
// Ports:
//   clk_in, rst_in         clock, async active-low reset
//   in_*                   instruction held in ex_mem
//   wb_*                   writeback towards mem_wb
//   fwd_*                  bypass towards ID (quiet while stalled)
//   stall_out, sb_empty    pipeline stall, store buffer drained
//   mc_*                   memory controller request/response
//
// state   | meaning
// IDLE    | no access in flight; issue a load, else drain the store head
// LD_WAIT | read request issued, waiting for mc_done
// ST_WAIT | head store issued, waiting for mc_done to pop it
// LD_DONE | load result registered; presented on wb_* this cycle
module mem_lsu_buffered
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_AW   = 5,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [XLEN-1:0]   in_rd_data,
  input  logic              in_rd_we,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_store_data,
  output logic [REG_AW-1:0] wb_rd_addr,
  output logic [XLEN-1:0]   wb_rd_data,
  output logic              wb_we,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [XLEN-1:0]   fwd_data,
  output logic              stall_out,
  output logic              sb_empty,
  output logic              mc_req,
  output logic              mc_we,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [XLEN-1:0]   mc_wdata,
  output logic [2:0]        mc_len,
  input  logic              mc_busy,
  input  logic              mc_done,
  input  logic [XLEN-1:0]   mc_rdata
);

  localparam int CW = $clog2(SB_DEPTH) + 1;

  lsu_state_e        state_q, state_d;
  logic              is_load, is_store;
  logic              sb_push, sb_pop, sb_full, sb_conflict;
  logic [CW-1:0]     sb_count;
  logic [ADDR_W-1:0] sb_head_addr;
  logic [XLEN-1:0]   sb_head_data;
  logic [2:0]        sb_head_len;
  logic              issue_ld, issue_st, ld_capture;
  logic [XLEN-1:0]   load_result_q;
  logic [1:0]        ld_size_q;
  logic              ld_uns_q;

  assign is_load  = in_valid & in_load;
  assign is_store = in_valid & in_store & ~in_load;
  assign sb_push  = is_store & ~sb_full;

  lsu_store_buffer #(
    .ADDR_W  (ADDR_W),
    .XLEN    (XLEN),
    .SB_DEPTH(SB_DEPTH)
  ) u_sb (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (sb_push),
    .pop       (sb_pop),
    .push_addr (in_addr),
    .push_data (store_mask(in_store_data, in_size)),
    .push_len  (mc_len_of(in_size)),
    .probe_word(in_addr[ADDR_W-1:2]),
    .head_addr (sb_head_addr),
    .head_data (sb_head_data),
    .head_len  (sb_head_len),
    .count     (sb_count),
    .full      (sb_full),
    .conflict  (sb_conflict)
  );

  // A load holds the pipe until its result is on wb_*; a store only when
  // the buffer is full, even if a pop happens the same cycle.
  always_comb begin
    stall_out = 1'b0;
    if (is_load)       stall_out = (state_q != LD_DONE);
    else if (is_store) stall_out = sb_full;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    issue_ld   = 1'b0;
    issue_st   = 1'b0;
    ld_capture = 1'b0;
    sb_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_load && !sb_conflict && !mc_busy) begin
          issue_ld = 1'b1;
          state_d  = LD_WAIT;
        end else if ((sb_count != '0) && !mc_busy) begin
          issue_st = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      LD_WAIT: if (mc_done) begin
        ld_capture = 1'b1;
        state_d    = LD_DONE;
      end
      ST_WAIT: if (mc_done) begin
        sb_pop  = 1'b1;
        state_d = IDLE;
      end
      LD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load size/sign are latched at issue so the extension does not depend on
  // ex_mem staying stable through the wait.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mc_req        <= 1'b0;
      mc_we         <= 1'b0;
      mc_addr       <= '0;
      mc_wdata      <= '0;
      mc_len        <= '0;
      ld_size_q     <= '0;
      ld_uns_q      <= 1'b0;
      load_result_q <= '0;
    end else begin
      mc_req <= issue_ld | issue_st;
      if (issue_ld) begin
        mc_we     <= 1'b0;
        mc_addr   <= in_addr;
        mc_wdata  <= '0;
        mc_len    <= mc_len_of(in_size);
        ld_size_q <= in_size;
        ld_uns_q  <= in_unsigned;
      end else if (issue_st) begin
        mc_we    <= 1'b1;
        mc_addr  <= sb_head_addr;
        mc_wdata <= sb_head_data;
        mc_len   <= sb_head_len;
      end
      if (ld_capture) load_result_q <= load_extend(mc_rdata, ld_size_q, ld_uns_q);
    end
  end

  // Nothing is written back for a stalled or absent instruction.
  always_comb begin
    wb_rd_addr = '0;
    wb_rd_data = '0;
    wb_we      = 1'b0;
    if (in_valid && !stall_out) begin
      wb_rd_addr = in_rd_addr;
      wb_rd_data = (state_q == LD_DONE && in_load) ? load_result_q : in_rd_data;
      wb_we      = in_rd_we;
    end
  end

  assign fwd_valid = wb_we;
  assign fwd_addr  = wb_rd_addr;
  assign fwd_data  = wb_rd_data;
  assign sb_empty  = (sb_count == '0);

endmodule

// File: tb/tb_mem_lsu_buffered.sv
module tb_mem_lsu_buffered;

  logic        clk_in, rst_in;
  logic        in_valid, in_rd_we, in_load, in_store, in_unsigned;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_rd_data, in_addr, in_store_data;
  logic [1:0]  in_size;
  logic [4:0]  wb_rd_addr, fwd_addr;
  logic [31:0] wb_rd_data, fwd_data;
  logic        wb_we, fwd_valid, stall_out, sb_empty;
  logic        mc_req, mc_we, mc_busy, mc_done;
  logic [31:0] mc_addr, mc_wdata, mc_rdata;
  logic [2:0]  mc_len;

  mem_lsu_buffered dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .in_valid(in_valid), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
    .in_rd_we(in_rd_we), .in_load(in_load), .in_store(in_store),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
    .in_store_data(in_store_data),
    .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data), .wb_we(wb_we),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .stall_out(stall_out), .sb_empty(sb_empty),
    .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_len(mc_len), .mc_busy(mc_busy), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // memory controller model: logs every request, optional auto-response
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  len;
  } req_t;
  req_t        log_q[$];
  logic        auto_resp   = 1'b0;
  logic        inject_done = 1'b0;
  int          resp_lat    = 3;
  logic [31:0] resp_data   = 32'h0;
  int          pend        = 0;

  initial begin
    req_t r;
    mc_done  = 1'b0;
    mc_rdata = 32'h0;
    forever begin
      @(posedge clk_in);
      #2;
      mc_done = inject_done;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mc_done  = 1'b1;
          mc_rdata = resp_data;
        end
      end
      if (mc_req === 1'b1) begin
        r.we = mc_we; r.addr = mc_addr; r.wdata = mc_wdata; r.len = mc_len;
        log_q.push_back(r);
        if (auto_resp) pend = resp_lat;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(); @(posedge clk_in); #1; endtask
  task automatic mid();  @(negedge clk_in);     endtask

  task automatic idle();
    in_valid = 0; in_load = 0; in_store = 0; in_rd_we = 0; in_unsigned = 0;
    in_rd_addr = 0; in_rd_data = 0; in_addr = 0; in_store_data = 0; in_size = 2'd2;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    idle();
    mc_busy = 1'b1; auto_resp = 1'b0; inject_done = 1'b0;
    tick(); tick();
    rst_in = 1'b1;
    tick();
    log_q.delete();
  endtask

  task automatic present_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    idle();
    in_valid = 1; in_store = 1; in_addr = a; in_store_data = d; in_size = sz;
  endtask

  task automatic present_load(input logic [31:0] a, input logic [1:0] sz, input logic uns, input logic [4:0] rd);
    idle();
    in_valid = 1; in_load = 1; in_rd_we = 1; in_rd_addr = rd; in_rd_data = 32'h5555AAAA;
    in_addr = a; in_size = sz; in_unsigned = uns;
  endtask

  task automatic wait_no_stall(input int budget, output int n);
    n = 0;
    mid();
    while (stall_out && n < budget) begin
      tick(); mid(); n++;
    end
    if (stall_out) begin
      nvec++; nfail++;
      $display("FAIL stall timeout: stall_out still 1 after %0d cycles", budget);
    end
  endtask

  task automatic wait_empty(input string nm, input int budget);
    int n = 0;
    mid();
    while (!sb_empty && n < budget) begin
      tick(); mid(); n++;
    end
    chk({nm, " sb_empty"}, sb_empty, 1);
  endtask

  task automatic chk_req(input string nm, input int idx, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] len);
    if (idx < log_q.size()) begin
      chk({nm, " we"},   log_q[idx].we,   we);
      chk({nm, " addr"}, log_q[idx].addr, a);
      if (we) chk({nm, " wdata"}, log_q[idx].wdata, d);
      chk({nm, " len"},  log_q[idx].len,  len);
    end else begin
      chk({nm, " missing request"}, log_q.size(), idx + 1);
    end
  endtask

  // load with mc_done 3 cycles after mc_req: result visible 5 cycles after presentation
  task automatic do_load(input string nm, input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         input logic [31:0] rdata, input logic [31:0] exp, input logic [2:0] len);
    int n;
    log_q.delete();
    mc_busy = 0; auto_resp = 1; resp_lat = 3; resp_data = rdata;
    present_load(a, sz, uns, 5'd10);
    wait_no_stall(40, n);
    chk({nm, " latency"}, n, 5);
    chk({nm, " wb_rd_data"}, wb_rd_data, exp);
    chk({nm, " wb_we"}, wb_we, 1);
    chk({nm, " fwd_data"}, fwd_data, exp);
    chk({nm, " fwd_addr"}, fwd_addr, 10);
    chk_req({nm, " read"}, 0, 1'b0, a, 32'h0, len);
    tick();
    idle();
    auto_resp = 0;
  endtask

  typedef struct {
    logic        valid, load, store, rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_we, e_stall;
  } vec_t;
  vec_t vecs[5];

  typedef struct {
    logic [31:0] addr, data;
    logic [1:0]  size;
    logic [31:0] e_wdata;
    logic [2:0]  e_len;
  } st_t;
  st_t sts[9];

  initial begin
    int n;
    vecs[0] = '{1, 0, 0, 1, 5'd5,  32'h00001234, 5'd5,  32'h00001234, 1, 0};
    vecs[1] = '{1, 0, 0, 0, 5'd7,  32'hDEADBEEF, 5'd7,  32'hDEADBEEF, 0, 0};
    vecs[2] = '{0, 0, 0, 1, 5'd9,  32'h00000005, 5'd0,  32'h00000000, 0, 0};
    vecs[3] = '{1, 0, 0, 1, 5'd31, 32'hFFFFFFFF, 5'd31, 32'hFFFFFFFF, 1, 0};
    vecs[4] = '{1, 0, 1, 0, 5'd0,  32'h00000077, 5'd0,  32'h00000077, 0, 0};

    sts[0] = '{32'h600, 32'h11111111, 2'd2, 32'h11111111, 3'd4};
    sts[1] = '{32'h605, 32'hAABBCCDD, 2'd0, 32'h000000DD, 3'd1};
    sts[2] = '{32'h60A, 32'h12345678, 2'd1, 32'h00005678, 3'd2};
    sts[3] = '{32'h60C, 32'hCAFEBABE, 2'd2, 32'hCAFEBABE, 3'd4};
    sts[4] = '{32'h611, 32'h0000FF80, 2'd0, 32'h00000080, 3'd1};
    sts[5] = '{32'h616, 32'hFFFF8001, 2'd1, 32'h00008001, 3'd2};
    sts[6] = '{32'h618, 32'h01020304, 2'd2, 32'h01020304, 3'd4};
    sts[7] = '{32'h61B, 32'hDEADBEEF, 2'd0, 32'h000000EF, 3'd1};
    sts[8] = '{32'h61E, 32'h9ABCDEF0, 2'd1, 32'h0000DEF0, 3'd2};

    idle();
    mc_busy = 1;
    rst_in  = 1;
    #2 rst_in = 0;
    #1;
    chk("reset stall_out", stall_out, 0);
    chk("reset sb_empty",  sb_empty, 1);
    chk("reset mc_req",    mc_req, 0);
    chk("reset mc_len",    mc_len, 0);
    chk("reset wb_we",     wb_we, 0);
    chk("reset fwd_valid", fwd_valid, 0);
    tick(); tick();
    rst_in = 1;
    tick();

    // table: ALU ops, bubble and a posted store, mc_busy held
    for (int i = 0; i < 5; i++) begin
      idle();
      in_valid = vecs[i].valid; in_load = vecs[i].load; in_store = vecs[i].store;
      in_rd_we = vecs[i].rd_we; in_rd_addr = vecs[i].rd_addr; in_rd_data = vecs[i].rd_data;
      in_addr = 32'h700; in_size = 2'd2;
      mid();
      chk($sformatf("vec%0d wb_rd_addr", i), wb_rd_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d wb_rd_data", i), wb_rd_data, vecs[i].e_data);
      chk($sformatf("vec%0d wb_we", i),      wb_we,      vecs[i].e_we);
      chk($sformatf("vec%0d stall_out", i),  stall_out,  vecs[i].e_stall);
      chk($sformatf("vec%0d fwd_valid", i),  fwd_valid,  vecs[i].e_we);
      chk($sformatf("vec%0d fwd_data", i),   fwd_data,   vecs[i].e_data);
      tick();
    end
    idle();
    mid();
    chk("posted store sb_empty", sb_empty, 0);

    // four SW with controller busy, fifth stalls, then FIFO drain
    do_reset();
    for (int i = 0; i < 4; i++) begin
      present_store(32'h100 + 32'(4 * i), 32'hA5A50000 + 32'(i), 2'd2);
      mid();
      chk($sformatf("sw%0d stall", i), stall_out, 0);
      tick();
    end
    present_store(32'h110, 32'hBBBBBBBB, 2'd2);
    mid();
    chk("fifth sw stall", stall_out, 1);
    chk("fifth sw wb_we", wb_we, 0);
    tick();
    idle();
    mc_busy = 0; auto_resp = 1; resp_lat = 2;
    wait_empty("sw drain", 100);
    chk("sw drain count", log_q.size(), 4);
    chk_req("sw drain 0", 0, 1'b1, 32'h100, 32'hA5A50000, 3'd4);
    chk_req("sw drain 1", 1, 1'b1, 32'h104, 32'hA5A50001, 3'd4);
    chk_req("sw drain 2", 2, 1'b1, 32'h108, 32'hA5A50002, 3'd4);
    chk_req("sw drain 3", 3, 1'b1, 32'h10C, 32'hA5A50003, 3'd4);
    auto_resp = 0;

    // load sizing and extension
    do_reset();
    do_load("LB",  32'h203, 2'd0, 1'b0, 32'h00000080, 32'hFFFFFF80, 3'd1);
    do_load("LBU", 32'h203, 2'd0, 1'b1, 32'h00000080, 32'h00000080, 3'd1);
    do_load("LH",  32'h202, 2'd1, 1'b0, 32'h00008001, 32'hFFFF8001, 3'd2);
    do_load("LHU", 32'h202, 2'd1, 1'b1, 32'h00008001, 32'h00008001, 3'd2);
    do_load("LW",  32'h204, 2'd2, 1'b0, 32'h87654321, 32'h87654321, 3'd4);

    // conflicting load waits for the store to drain
    do_reset();
    present_store(32'h300, 32'h11223344, 2'd2);
    tick();
    present_load(32'h302, 2'd2, 1'b0, 5'd3);
    mid();
    chk("conflict ld stall", stall_out, 1);
    mc_busy = 0; auto_resp = 1; resp_lat = 2; resp_data = 32'hCAFEF00D;
    wait_no_stall(60, n);
    chk("conflict ld data", wb_rd_data, 32'hCAFEF00D);
    chk("conflict req count", log_q.size(), 2);
    chk_req("conflict first", 0, 1'b1, 32'h300, 32'h11223344, 3'd4);
    chk_req("conflict second", 1, 1'b0, 32'h302, 32'h0, 3'd4);
    tick();
    idle();
    auto_resp = 0;

    // non-conflicting load bypasses the buffered store
    do_reset();
    present_store(32'h300, 32'h11223344, 2'd2);
    tick();
    present_load(32'h400, 2'd2, 1'b0, 5'd4);
    mc_busy = 0; auto_resp = 1; resp_lat = 2; resp_data = 32'h0BADF00D;
    wait_no_stall(60, n);
    chk("bypass ld data", wb_rd_data, 32'h0BADF00D);
    chk_req("bypass first", 0, 1'b0, 32'h400, 32'h0, 3'd4);
    tick();
    idle();
    wait_empty("bypass drain", 60);
    chk_req("bypass store", 1, 1'b1, 32'h300, 32'h11223344, 3'd4);
    auto_resp = 0;

    // push+pop at count 2, full-with-pop stall, wrap over 9 mixed stores
    do_reset();
    for (int i = 0; i < 2; i++) begin
      present_store(sts[i].addr, sts[i].data, sts[i].size);
      tick();
    end
    idle();
    mc_busy = 0;
    tick();
    mc_busy = 1;
    present_store(sts[2].addr, sts[2].data, sts[2].size);
    inject_done = 1;
    mid();
    chk("push+pop stall", stall_out, 0);
    tick();
    inject_done = 0;
    for (int i = 3; i < 5; i++) begin
      present_store(sts[i].addr, sts[i].data, sts[i].size);
      mid();
      chk($sformatf("refill s%0d stall", i), stall_out, 0);
      tick();
    end
    present_store(sts[5].addr, sts[5].data, sts[5].size);
    mid();
    chk("full stall", stall_out, 1);
    mc_busy = 0;
    tick();
    mc_busy = 1;
    inject_done = 1;
    mid();
    chk("full stall with pop", stall_out, 1);
    tick();
    inject_done = 0;
    mid();
    chk("after pop stall", stall_out, 0);
    tick();
    idle();
    mc_busy = 0; auto_resp = 1; resp_lat = 1;
    wait_empty("wrap drain a", 100);
    mc_busy = 1;
    tick();
    for (int i = 6; i < 9; i++) begin
      present_store(sts[i].addr, sts[i].data, sts[i].size);
      mid();
      chk($sformatf("wrap s%0d stall", i), stall_out, 0);
      tick();
    end
    idle();
    mc_busy = 0;
    wait_empty("wrap drain b", 100);
    chk("wrap req count", log_q.size(), 9);
    for (int i = 0; i < 9; i++)
      chk_req($sformatf("wrap s%0d", i), i, 1'b1, sts[i].addr, sts[i].e_wdata, sts[i].e_len);
    auto_resp = 0;

    // reset during LD_WAIT, then a stale mc_done
    do_reset();
    mc_busy = 0;
    present_load(32'h500, 2'd2, 1'b0, 5'd9);
    tick();
    tick();
    rst_in = 0;
    idle();
    #1;
    chk("midrst mc_req",    mc_req, 0);
    chk("midrst mc_we",     mc_we, 0);
    chk("midrst mc_addr",   mc_addr, 0);
    chk("midrst mc_wdata",  mc_wdata, 0);
    chk("midrst mc_len",    mc_len, 0);
    chk("midrst stall_out", stall_out, 0);
    chk("midrst sb_empty",  sb_empty, 1);
    chk("midrst wb_rd_data", wb_rd_data, 0);
    chk("midrst fwd_valid", fwd_valid, 0);
    tick();
    rst_in = 1;
    tick();
    inject_done = 1;
    mid();
    chk("stale done wb_we", wb_we, 0);
    tick();
    inject_done = 0;
    mid();
    chk("stale done mc_req", mc_req, 0);
    chk("stale done stall", stall_out, 0);
    tick();
    do_load("post-reset LW", 32'h504, 2'd2, 1'b0, 32'h13572468, 32'h13572468, 3'd4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
